bitwise_logic_unit: RTL and testbench

Parametrised, registered bitwise logic unit that applies one of eight selectable logic operations to two WIDTH-bit operands. Results are buffered in an output FIFO behind valid/ready handshakes on both sides. A chain mode feeds the previous result back in as operand A, so multi-step logic reductions can stream without external feedback. The block is the datapath logic stage between operand sources and downstream consumers.

---
 rtl/bitwise_logic_unit_if.sv | 39 +++
 rtl/bitwise_logic_unit.sv | 116 +++++++++++
 tb/tb_bitwise_logic_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bitwise_logic_unit_if.sv
// rtl/bitwise_logic_unit_if.sv - operand/result handshake bundle for bitwise_logic_unit
// zero/parity members exist only when BLU_FLAGS_EN is defined.
interface bitwise_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               op;
    logic                     chain;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         y;
    logic [$clog2(DEPTH):0]   level;
`ifdef BLU_FLAGS_EN
    logic                     zero;
    logic                     parity;

    modport master (
        output in_valid, op, chain, a, b, out_ready,
        input  in_ready, out_valid, y, level, zero, parity
    );
    modport slave (
        input  in_valid, op, chain, a, b, out_ready,
        output in_ready, out_valid, y, level, zero, parity
    );
`else
    modport master (
        output in_valid, op, chain, a, b, out_ready,
        input  in_ready, out_valid, y, level
    );
    modport slave (
        input  in_valid, op, chain, a, b, out_ready,
        output in_ready, out_valid, y, level
    );
`endif
endinterface

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - registered 8-op bitwise logic unit with chain accumulator and output FIFO
// Define BLU_FLAGS_EN to store and present per-entry zero/parity flags.
module bitwise_logic_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bitwise_logic_unit_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             accept;
    logic             pop;
    logic             not_empty;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] result;

    // DEPTH is a power of two, so the level MSB is set only when full.
    assign bus.in_ready  = ~level_q[PW];
    assign not_empty     = (level_q != '0);
    assign bus.out_valid = not_empty;
    assign bus.y         = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.level     = level_q;

    assign accept = bus.in_valid & ~level_q[PW];
    assign pop    = bus.out_ready & not_empty;
    assign a_sel  = bus.chain ? acc_q : bus.a;

    always_comb begin
        result = '0;
        case (bus.op)
            3'd0: result = a_sel | bus.b;
            3'd1: result = a_sel & bus.b;
            3'd2: result = ~(a_sel | bus.b);
            3'd3: result = ~(a_sel & bus.b);
            3'd4: result = a_sel ^ bus.b;
            3'd5: result = ~(a_sel ^ bus.b);
            3'd6: result = ~a_sel;
            3'd7: result = bus.b;
            default: result = '0;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (accept) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            acc_d           = result;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is left uncleared; y is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef BLU_FLAGS_EN
    logic zero_mem_q [DEPTH];
    logic zero_mem_d [DEPTH];
    logic par_mem_q  [DEPTH];
    logic par_mem_d  [DEPTH];

    assign bus.zero   = not_empty & zero_mem_q[rd_ptr_q];
    assign bus.parity = not_empty & par_mem_q[rd_ptr_q];

    always_comb begin
        zero_mem_d = zero_mem_q;
        par_mem_d  = par_mem_q;
        if (accept) begin
            zero_mem_d[wr_ptr_q] = (result == '0);
            par_mem_d[wr_ptr_q]  = ^result;
        end
    end

    always_ff @(posedge clk) begin
        zero_mem_q <= zero_mem_d;
        par_mem_q  <= par_mem_d;
    end
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - directed self-checking bench for bitwise_logic_unit
module tb_bitwise_logic_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bitwise_logic_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    bitwise_logic_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] basic_exp [8];

    initial begin
        basic_exp[0] = 8'hFF; basic_exp[1] = 8'h00; basic_exp[2] = 8'h00; basic_exp[3] = 8'hFF;
        basic_exp[4] = 8'hFF; basic_exp[5] = 8'h00; basic_exp[6] = 8'h3A; basic_exp[7] = 8'h3A;

        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.chain     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_level", bus.level, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_in_ready", bus.in_ready, 1);
`ifdef BLU_FLAGS_EN
        chk("rst_zero", bus.zero, 0);
        chk("rst_parity", bus.parity, 0);
`endif

        // basic ops
        bus.out_ready = 1'b1;
        bus.a = 8'hC5;
        bus.b = 8'h3A;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.op = 3'(i);
            tick();
            chk($sformatf("op%0d_y", i), bus.y, basic_exp[i]);
            chk($sformatf("op%0d_level", i), bus.level, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("drain_level", bus.level, 0);
        chk("drain_y_masked", bus.y, 0);

        // chain
        bus.in_valid = 1'b1;
        bus.op = 3'd7; bus.chain = 1'b0; bus.b = 8'h0F;
        tick();
        chk("chain0", bus.y, 8'h0F);
        bus.op = 3'd4; bus.chain = 1'b1; bus.b = 8'hFF; bus.a = 8'h00;
        tick();
        chk("chain1", bus.y, 8'hF0);
        bus.op = 3'd1; bus.chain = 1'b1; bus.b = 8'h3C;
        tick();
        chk("chain2", bus.y, 8'h30);
        bus.in_valid = 1'b0;
        bus.chain = 1'b0;
        tick();
        chk("chain_drain_valid", bus.out_valid, 0);

        // full / backpressure
        bus.out_ready = 1'b0;
        bus.op = 3'd7;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.b = 8'(i);
            tick();
        end
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_level", bus.level, 4);
        chk("full_y", bus.y, 1);
        bus.b = 8'd5;
        tick();
        chk("full_hold_level", bus.level, 4);
        chk("full_hold_y", bus.y, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_y2", bus.y, 2);
        chk("bp_level3a", bus.level, 3);
        chk("bp_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_y3", bus.y, 3);
        chk("bp_level3b", bus.level, 3);
        tick();
        chk("bp_y4", bus.y, 4);
        tick();
        chk("bp_y5", bus.y, 5);
        chk("bp_level1", bus.level, 1);
        tick();
        chk("bp_empty", bus.out_valid, 0);

        // simultaneous accept/pop across pointer wrap
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.b = 8'h10;
        tick();
        bus.out_ready = 1'b1;
        chk("wrap_start_y", bus.y, 8'h10);
        for (int k = 1; k <= 10; k++) begin
            bus.b = 8'(8'h10 + k);
            tick();
            chk($sformatf("wrap%0d_level", k), bus.level, 1);
            chk($sformatf("wrap%0d_y", k), bus.y, 8'h10 + k);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("wrap_drain", bus.level, 0);

        // reset mid-stream
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 3'd7;
        bus.b = 8'h11; tick();
        bus.b = 8'h22; tick();
        bus.b = 8'hAA; tick();
        chk("pre_rst_level", bus.level, 3);
        bus.b = 8'h55;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_y", bus.y, 0);
        bus.in_valid = 1'b1;
        bus.op = 3'd0; bus.chain = 1'b1; bus.b = 8'h01;
        bus.out_ready = 1'b1;
        tick();
        chk("post_rst_chain", bus.y, 8'h01);
        bus.in_valid = 1'b0;
        bus.chain = 1'b0;
        tick();

`ifdef BLU_FLAGS_EN
        bus.in_valid = 1'b1;
        bus.op = 3'd1; bus.a = 8'hF0; bus.b = 8'h0F;
        tick();
        chk("flag_and_y", bus.y, 8'h00);
        chk("flag_and_zero", bus.zero, 1);
        chk("flag_and_parity", bus.parity, 0);
        bus.op = 3'd7; bus.b = 8'h07;
        tick();
        chk("flag_pass_y", bus.y, 8'h07);
        chk("flag_pass_zero", bus.zero, 0);
        chk("flag_pass_parity", bus.parity, 1);
        bus.in_valid = 1'b0;
        tick();
        chk("flag_empty_zero", bus.zero, 0);
        chk("flag_empty_parity", bus.parity, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
